// File: rtl/mips_fetch_stage_if.sv
// Instruction-memory fetch bus between the fetch stage (master) and instruction memory (slave).
// The memory accepts a request and returns its word in the same cycle that imem_ready is high.
interface mips_fetch_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rdata,
    input  imem_ready
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rdata,
    output imem_ready
  );
endinterface

// File: rtl/mips_fetch_stage.sv
// MIPS instruction-fetch stage with IF/ID register, one-entry skid buffer and redirects.
// Optional fetch/bubble performance counters are enabled by defining IF_PERF_CNT_EN.
module mips_fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0180
) (
  input  logic                      clk,
  input  logic                      rst_n,
  mips_fetch_stage_if.master        imem_bus,
  input  logic                      stall,
  input  logic                      jump,
  input  logic [31:0]               jump_target,
  input  logic                      branch_taken,
  input  logic [31:0]               branch_target,
  input  logic                      exception,
  output logic                      id_valid,
  output logic [31:0]               id_instr,
  output logic [31:0]               id_pc_plus4,
  output logic [5:0]                Op_code,
  output logic [4:0]                Rs,
  output logic [4:0]                Rt,
  output logic [4:0]                Shamt,
  output logic [5:0]                Funct,
  output logic [31:0]               epc
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]               fetch_cnt,
  output logic [31:0]               bubble_cnt
`endif
);

  typedef enum logic [1:0] {StBoot, StFetch, StBuf} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        id_valid_q, id_valid_d;
  logic [31:0] id_instr_q, id_instr_d;
  logic [31:0] id_pc4_q, id_pc4_d;
  logic [31:0] buf_instr_q, buf_instr_d;
  logic [31:0] buf_pc4_q, buf_pc4_d;
  logic [31:0] epc_q, epc_d;

  logic        exc_taken;
  logic        redirect;
  logic [31:0] pc_plus4;

  // A bubble in IF/ID decodes as illegal downstream, so its exception must be ignored.
  assign exc_taken = exception & id_valid_q;
  assign redirect  = exc_taken | branch_taken | jump;
  assign pc_plus4  = pc_q + 32'd4;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    id_valid_d  = id_valid_q;
    id_instr_d  = id_instr_q;
    id_pc4_d    = id_pc4_q;
    buf_instr_d = buf_instr_q;
    buf_pc4_d   = buf_pc4_q;
    epc_d       = epc_q;

    if (redirect) begin
      if (exc_taken) begin
        pc_d  = {EXC_VECTOR[31:2], 2'b00};
        epc_d = id_pc4_q - 32'd4;
      end else if (branch_taken) begin
        pc_d = {branch_target[31:2], 2'b00};
      end else begin
        pc_d = {jump_target[31:2], 2'b00};
      end
      id_valid_d  = 1'b0;
      id_instr_d  = 32'h0;
      id_pc4_d    = 32'h0;
      buf_instr_d = 32'h0;
      buf_pc4_d   = 32'h0;
      state_d     = StFetch;
    end else begin
      unique case (state_q)
        StBoot: begin
          state_d = StFetch;
        end
        StFetch: begin
          if (imem_bus.imem_ready) begin
            pc_d = pc_plus4;
            if (stall) begin
              buf_instr_d = imem_bus.imem_rdata;
              buf_pc4_d   = pc_plus4;
              state_d     = StBuf;
            end else begin
              id_valid_d = 1'b1;
              id_instr_d = imem_bus.imem_rdata;
              id_pc4_d   = pc_plus4;
            end
          end else if (!stall) begin
            id_valid_d = 1'b0;
            id_instr_d = 32'h0;
            id_pc4_d   = 32'h0;
          end
        end
        StBuf: begin
          if (!stall) begin
            id_valid_d  = 1'b1;
            id_instr_d  = buf_instr_q;
            id_pc4_d    = buf_pc4_q;
            buf_instr_d = 32'h0;
            buf_pc4_d   = 32'h0;
            state_d     = StFetch;
          end
        end
        default: begin
          state_d = StBoot;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StBoot;
      pc_q        <= {RESET_PC[31:2], 2'b00};
      id_valid_q  <= 1'b0;
      id_instr_q  <= 32'h0;
      id_pc4_q    <= 32'h0;
      buf_instr_q <= 32'h0;
      buf_pc4_q   <= 32'h0;
      epc_q       <= 32'h0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      id_valid_q  <= id_valid_d;
      id_instr_q  <= id_instr_d;
      id_pc4_q    <= id_pc4_d;
      buf_instr_q <= buf_instr_d;
      buf_pc4_q   <= buf_pc4_d;
      epc_q       <= epc_d;
    end
  end

  assign imem_bus.imem_req  = (state_q == StFetch);
  assign imem_bus.imem_addr = {pc_q[31:2], 2'b00};

  assign id_valid    = id_valid_q;
  assign id_instr    = id_instr_q;
  assign id_pc_plus4 = id_pc4_q;
  assign epc         = epc_q;

  assign Op_code = id_instr_q[31:26];
  assign Rs      = id_instr_q[25:21];
  assign Rt      = id_instr_q[20:16];
  assign Shamt   = id_instr_q[10:6];
  assign Funct   = id_instr_q[5:0];

`ifdef IF_PERF_CNT_EN
  logic        load_valid;
  logic        load_bubble;
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] bubble_cnt_q, bubble_cnt_d;

  always_comb begin
    load_valid   = !redirect && !stall &&
                   (((state_q == StFetch) && imem_bus.imem_ready) || (state_q == StBuf));
    load_bubble  = redirect ||
                   ((state_q == StFetch) && !imem_bus.imem_ready && !stall);
    fetch_cnt_d  = fetch_cnt_q + {31'b0, load_valid};
    bubble_cnt_d = bubble_cnt_q + {31'b0, load_bubble};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_q  <= 32'h0;
      bubble_cnt_q <= 32'h0;
    end else begin
      fetch_cnt_q  <= fetch_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign fetch_cnt  = fetch_cnt_q;
  assign bubble_cnt = bubble_cnt_q;
`endif

endmodule
